// File: rtl/instruction_sequencer.sv
// Program sequencer: streams a host-loaded program onto the shared core instruction bus.
// Optional multi-pass repeat is built when INSTRUCTION_SEQUENCER_REPEAT_EN is defined.
module instruction_sequencer #(
  parameter int PROG_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [17:0]       load_data_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic [15:0]       repeat_i,
  output logic [17:0]       instruction_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [15:0]       pass_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [17:0]     NOP     = 18'h00000;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [17:0]       mem [PROG_DEPTH];
  logic [17:0]       rd_data_p1;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] pc, pc_nxt, last_pc;

  // Index of the final word of a pass, with the requested length clamped to the memory depth.
  function automatic logic [ADDR_W-1:0] last_pc_of(input logic [ADDR_W:0] len);
    logic [ADDR_W:0] n;
    n = (len > DEPTH_L) ? DEPTH_L : len;
    n = n - (ADDR_W+1)'(1);
    return n[ADDR_W-1:0];
  endfunction

`ifdef INSTRUCTION_SEQUENCER_REPEAT_EN
  logic [15:0] pass, pass_nxt, last_pass;

  function automatic logic [15:0] last_pass_of(input logic [15:0] rep);
    return (rep == 16'd0) ? 16'd0 : rep - 16'd1;
  endfunction
`else
  logic [15:0] unused_repeat;
  assign unused_repeat = repeat_i;
`endif

  always_comb begin
    state_nxt = state;
    rd_addr   = '0;
    pc_nxt    = pc;
`ifdef INSTRUCTION_SEQUENCER_REPEAT_EN
    pass_nxt  = pass;
`endif
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = (length_i == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (abort_i) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RUN;
          rd_addr   = '0;
          pc_nxt    = '0;
`ifdef INSTRUCTION_SEQUENCER_REPEAT_EN
          pass_nxt  = '0;
`endif
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_nxt = S_IDLE;
        end else if (pc < last_pc) begin
          rd_addr = pc + ADDR_W'(1);
          pc_nxt  = pc + ADDR_W'(1);
`ifdef INSTRUCTION_SEQUENCER_REPEAT_EN
        end else if (pass < last_pass) begin
          // Wrap straight into the next pass with no idle cycle.
          rd_addr  = '0;
          pc_nxt   = '0;
          pass_nxt = pass + 16'd1;
`endif
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      pc    <= '0;
`ifdef INSTRUCTION_SEQUENCER_REPEAT_EN
      pass  <= '0;
`endif
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
`ifdef INSTRUCTION_SEQUENCER_REPEAT_EN
      pass  <= pass_nxt;
`endif
    end
  end

  // Run parameters are frozen at start so the host may change them mid-run.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && start_i) begin
      last_pc   <= last_pc_of(length_i);
`ifdef INSTRUCTION_SEQUENCER_REPEAT_EN
      last_pass <= last_pass_of(repeat_i);
`endif
    end
  end

  // Stage p1: synchronous program read; writes are locked out while a run is active.
  always_ff @(posedge clk_i) begin
    if (load_en_i && !busy_o) mem[load_addr_i] <= load_data_i;
    rd_data_p1 <= mem[rd_addr];
  end

  assign busy_o        = (state == S_FETCH) || (state == S_RUN);
  assign done_o        = (state == S_DONE);
  assign instruction_o = (state == S_RUN) ? rd_data_p1 : NOP;
  assign pc_o          = pc;
`ifdef INSTRUCTION_SEQUENCER_REPEAT_EN
  assign pass_o        = pass;
`else
  assign pass_o        = '0;
`endif

endmodule
